// File: rtl/fch_sram_bridge.sv
// Instruction-fetch bridge: fetch request/response channels to a single-port SRAM
// with one-cycle read latency, plus an in-order response buffer for back-pressure.
module fch_sram_bridge #(
  parameter int ADDR_WIDTH = 12,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_fch_req_vld,
  output logic                  o_fch_req_rdy,
  input  logic [31:0]           i_fch_req_pc,
  output logic                  o_fch_rsp_vld,
  input  logic                  i_fch_rsp_rdy,
  output logic [31:0]           o_fch_rsp_ir,
  output logic                  sram_cs,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  input  logic [31:0]           sram_rdata
);

  localparam int PTR_W = (RSP_DEPTH > 2) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);
  localparam logic [32:0]      PC_LIMIT = 33'(64'd4 << ADDR_WIDTH);

  logic             r_rd_pend;
  logic             r_rd_oor;
  logic [CNT_W-1:0] r_fifo_cnt;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [31:0]      r_fifo_mem [RSP_DEPTH];

  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_occ;
  logic [31:0]      w_rd_data;
  logic             w_rsp_vld;
  logic [31:0]      w_rsp_ir;
  logic             w_rsp_hsk;
  logic             w_req_rdy;
  logic             w_req_hsk;
  logic             w_in_range;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Response selection (FIFO head or bypass of the pending read) and handshakes.
  always_comb begin
    w_fifo_empty = (r_fifo_cnt == {CNT_W{1'b0}});
    w_occ        = r_fifo_cnt + CNT_W'(r_rd_pend);
    w_rd_data    = r_rd_oor ? 32'h0000_0000 : sram_rdata;
    w_in_range   = ({1'b0, i_fch_req_pc} < PC_LIMIT);
    if (w_fifo_empty) begin
      w_rsp_vld = rst_n & r_rd_pend;
      w_rsp_ir  = w_rd_data;
    end else begin
      w_rsp_vld = rst_n;
      w_rsp_ir  = r_fifo_mem[r_rd_ptr];
    end
    w_rsp_hsk = w_rsp_vld & i_fch_rsp_rdy;
    // A pop this cycle frees a slot, so rdy may rise while full.
    w_req_rdy = rst_n & ((w_occ < DEPTH_C) | w_rsp_hsk);
    w_req_hsk = i_fch_req_vld & w_req_rdy;
    w_pop     = w_rsp_hsk & ~w_fifo_empty;
    w_push    = rst_n & r_rd_pend & ~(w_fifo_empty & w_rsp_hsk);
  end

  assign o_fch_req_rdy = w_req_rdy;
  assign o_fch_rsp_vld = w_rsp_vld;
  assign o_fch_rsp_ir  = w_rsp_ir;
  assign sram_cs       = w_req_hsk & w_in_range;
  assign sram_addr     = i_fch_req_pc[ADDR_WIDTH+1:2];

  // Pending-read flags, FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_oor   <= 1'b0;
      r_fifo_cnt <= {CNT_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
    end else begin
      r_rd_pend  <= w_req_hsk;
      r_rd_oor   <= w_req_hsk & ~w_in_range;
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  // Response buffer storage; contents are only meaningful under the count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= w_rd_data;
    end
  end

endmodule

// File: tb/tb_fch_sram_bridge.sv
// Bench for fch_sram_bridge: directed scenarios with literal expectations plus a
// queue-based model checked every cycle, then a long random vld/rdy run.
module tb_fch_sram_bridge;
  localparam int AW    = 12;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_vld;
  logic          req_rdy;
  logic [31:0]   req_pc;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [31:0]   rsp_ir;
  logic          sram_cs;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_rdata;

  logic [31:0] mem [1 << AW];
  logic [31:0] exp_q [$];
  bit          hold_r = 1'b0;
  logic [31:0] hold_ir = 32'h0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  fch_sram_bridge #(.ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_fch_req_vld (req_vld),
    .o_fch_req_rdy (req_rdy),
    .i_fch_req_pc  (req_pc),
    .o_fch_rsp_vld (rsp_vld),
    .i_fch_rsp_rdy (rsp_rdy),
    .o_fch_rsp_ir  (rsp_ir),
    .sram_cs       (sram_cs),
    .sram_addr     (sram_addr),
    .sram_rdata    (sram_rdata)
  );

  // Synchronous SRAM: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (sram_cs) sram_rdata <= mem[sram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    if (pc < (32'd4 << AW)) return mem[pc[AW+1:2]];
    else return 32'h0000_0000;
  endfunction

  function automatic bit in_range(input logic [31:0] pc);
    return pc < (32'd4 << AW);
  endfunction

  // Model: every accepted fetch owes exactly one response, in order.
  always @(negedge clk) begin
    bit exp_vld;
    bit exp_rdy;
    bit rsp_hsk;
    bit req_hsk;
    if (!rst_n) begin
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("rst_sram_cs", 32'(sram_cs), 32'd0);
      exp_q.delete();
      hold_r = 1'b0;
    end else begin
      exp_vld = (exp_q.size() > 0);
      rsp_hsk = exp_vld && rsp_rdy;
      exp_rdy = (exp_q.size() < DEPTH) || rsp_hsk;
      req_hsk = req_vld && exp_rdy;
      chk("rsp_vld", 32'(rsp_vld), 32'(exp_vld));
      if (exp_vld) chk("rsp_ir", rsp_ir, exp_q[0]);
      if (hold_r) chk("rsp_hold_ir", rsp_ir, hold_ir);
      chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
      chk("sram_cs", 32'(sram_cs), 32'(req_hsk && in_range(req_pc)));
      if (req_hsk && in_range(req_pc)) chk("sram_addr", 32'(sram_addr), req_pc >> 2);
      hold_r  = exp_vld && !rsp_rdy;
      hold_ir = rsp_ir;
      if (rsp_hsk) void'(exp_q.pop_front());
      if (req_hsk) exp_q.push_back(word_at(req_pc));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_vld = 1'b0; req_pc = 32'h0; rsp_rdy = 1'b1; sram_rdata = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[4] = 32'h0010_0093;

    // Reset
    repeat (3) tick();
    #2;
    chk("reset_req_rdy", 32'(req_rdy), 32'd0);
    chk("reset_rsp_vld", 32'(rsp_vld), 32'd0);
    tick(); rst_n = 1'b1; #2;
    chk("first_req_rdy", 32'(req_rdy), 32'd1);
    chk("idle_rsp_vld", 32'(rsp_vld), 32'd0);

    // Single fetch
    tick(); req_vld = 1'b1; req_pc = 32'h0000_0010; #2;
    chk("single_cs", 32'(sram_cs), 32'd1);
    chk("single_addr", 32'(sram_addr), 32'd4);
    tick(); req_vld = 1'b0; #2;
    chk("single_vld", 32'(rsp_vld), 32'd1);
    chk("single_ir", rsp_ir, 32'h0010_0093);
    tick(); #2;
    chk("single_done", 32'(rsp_vld), 32'd0);

    // Streaming
    for (int k = 0; k < 4; k++) begin
      tick(); req_vld = 1'b1; req_pc = 32'(4 * k); #2;
      chk("stream_req_rdy", 32'(req_rdy), 32'd1);
      if (k > 0) chk("stream_ir", rsp_ir, 32'hC0DE_0000 | 32'(k - 1));
    end
    tick(); req_vld = 1'b0; #2;
    chk("stream_last_ir", rsp_ir, 32'hC0DE_0003);
    tick(); #2;
    chk("stream_done", 32'(rsp_vld), 32'd0);

    // Back-pressure
    tick(); rsp_rdy = 1'b0; req_vld = 1'b1; req_pc = 32'h20; #2;
    chk("bp_rdy0", 32'(req_rdy), 32'd1);
    tick(); req_pc = 32'h24; #2;
    chk("bp_rdy1", 32'(req_rdy), 32'd1);
    chk("bp_ir1", rsp_ir, 32'hC0DE_0008);
    tick(); req_pc = 32'h28; #2;
    chk("bp_full2", 32'(req_rdy), 32'd0);
    chk("bp_hold2", rsp_ir, 32'hC0DE_0008);
    tick(); #2;
    chk("bp_full3", 32'(req_rdy), 32'd0);
    chk("bp_hold3", rsp_ir, 32'hC0DE_0008);
    tick(); rsp_rdy = 1'b1; #2;
    chk("bp_pop_rdy", 32'(req_rdy), 32'd1);
    chk("bp_pop_ir", rsp_ir, 32'hC0DE_0008);
    tick(); req_vld = 1'b0; #2;
    chk("bp_ir_9", rsp_ir, 32'hC0DE_0009);
    tick(); #2;
    chk("bp_ir_a", rsp_ir, 32'hC0DE_000A);
    tick(); #2;
    chk("bp_done", 32'(rsp_vld), 32'd0);

    // Out of range
    tick(); req_vld = 1'b1; req_pc = 32'h0000_4000; #2;
    chk("oor_cs", 32'(sram_cs), 32'd0);
    chk("oor_rdy", 32'(req_rdy), 32'd1);
    tick(); req_pc = 32'h14; #2;
    chk("oor_vld", 32'(rsp_vld), 32'd1);
    chk("oor_ir", rsp_ir, 32'h0000_0000);
    chk("oor_next_cs", 32'(sram_cs), 32'd1);
    chk("oor_next_addr", 32'(sram_addr), 32'd5);
    tick(); req_vld = 1'b0; #2;
    chk("oor_next_ir", rsp_ir, 32'hC0DE_0005);
    tick(); #2;

    // Reset mid-operation
    tick(); rsp_rdy = 1'b0; req_vld = 1'b1; req_pc = 32'h30;
    tick(); req_pc = 32'h34;
    tick(); req_vld = 1'b0; #2;
    chk("mr_ir", rsp_ir, 32'hC0DE_000C);
    tick(); #2;
    chk("mr_full", 32'(req_rdy), 32'd0);
    tick(); rst_n = 1'b0; #2;
    chk("mr_rst_vld", 32'(rsp_vld), 32'd0);
    chk("mr_rst_rdy", 32'(req_rdy), 32'd0);
    tick(); rst_n = 1'b1; rsp_rdy = 1'b1; #2;
    chk("mr_after_vld", 32'(rsp_vld), 32'd0);
    chk("mr_after_rdy", 32'(req_rdy), 32'd1);
    tick(); #2;
    chk("mr_no_stale", 32'(rsp_vld), 32'd0);

    // Random traffic against the model
    for (int c = 0; c < 10000; c++) begin
      tick();
      req_vld = 1'($urandom_range(0, 1));
      req_pc  = 32'($urandom_range(0, 4300)) << 2;
      rsp_rdy = ($urandom_range(0, 3) != 0);
    end
    tick(); req_vld = 1'b0; rsp_rdy = 1'b1;
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fch_sram_bridge.md
# fch_sram_bridge

Instruction-fetch memory bridge between the fetch unit's fetch-request/fetch-response channels and a single-port synchronous instruction SRAM. It accepts one fetch request per cycle and issues a one-cycle-latency SRAM read. Read data is returned in order on the response channel. A small response buffer absorbs back-pressure from the fetch unit without dropping reads.

## Interface
Parameters:
- ADDR_WIDTH, 12: SRAM word-address bits; the SRAM holds 2^ADDR_WIDTH 32-bit words (16 KiB by default).
- RSP_DEPTH, 2: maximum number of reads in flight plus buffered responses; minimum 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- fch_req_slv  fch_req_if_t.slv  -  vld/rdy handshake; pkt.pc is a `RV_PC_SIZE byte address.
- fch_rsp_mst  fch_rsp_if_t.mst  -  vld/rdy handshake; pkt.ir is a `RV_IR_SIZE instruction word.
- sram_cs  out  1  SRAM read enable.
- sram_addr  out  ADDR_WIDTH  SRAM word address, equal to pc[ADDR_WIDTH+1:2].
- sram_rdata  in  32  SRAM read data, valid in the cycle after sram_cs.

## Operation
- Request handshake: req_hsk = fch_req_slv.vld & fch_req_slv.rdy.
- Response handshake: rsp_hsk = fch_rsp_mst.vld & fch_rsp_mst.rdy.
- Occupancy occ = rd_pend (0/1) + fifo_cnt (0..RSP_DEPTH).
- fch_req_slv.rdy = rst_n & ((occ < RSP_DEPTH) | rsp_hsk). This is combinational and contains no path from fch_req_slv.vld.
- In-range request (pc < 4·2^ADDR_WIDTH):
  - On req_hsk, sram_cs=1 and sram_addr=pc[ADDR_WIDTH+1:2] in the same cycle.
  - rd_pend is set next cycle and rd_oor is cleared.
- Out-of-range request:
  - sram_cs stays 0.
  - rd_pend is set and rd_oor=1.
  - The returned ir is 32'h0000_0000 (illegal instruction, which is trapped downstream).
- pc[1:0] is ignored and the word is fetched. Alignment is guaranteed by the fetch unit.
- Response source:
  - If fifo_cnt=0, the response comes from the pending read: fch_rsp_mst.vld = rd_pend and pkt.ir = rd_oor ? 0 : sram_rdata (bypass).
  - Otherwise the response comes from the FIFO head.
- When rd_pend=1 and the read is not consumed this cycle (FIFO non-empty or rsp_hsk=0), the read data is pushed into the FIFO.
- Responses are strictly in request order. No request is dropped or duplicated.
- FIFO pointers wrap modulo RSP_DEPTH. A simultaneous push and pop leaves fifo_cnt unchanged.
- rd_pend next = req_hsk. A new request and a completing read in the same cycle is normal pipelined operation.
- There is no flush input. Redirects are handled by the fetch unit, which consumes every response it requested.

## Timing
- Latency: req_hsk at cycle N gives fch_rsp_mst.vld at N+1 when the FIFO is empty. Sustained throughput is 1 fetch/cycle while fch_rsp_mst.rdy=1.
- The response stays stable (vld and ir held) until rsp_hsk. The bridge never retracts vld.
- Full condition: occ=RSP_DEPTH and no rsp_hsk gives fch_req_slv.rdy=0. A pop in the same cycle re-enables rdy in that cycle.
- Empty condition: occ=0 gives fch_rsp_mst.vld=0.
- Reset (rst_n=0 at a clock edge) clears rd_pend, rd_oor, fifo_cnt and the pointers. This applies mid-operation too: all in-flight and buffered responses are discarded.
- Output values while rst_n=0:
  - fch_req_slv.rdy=0
  - fch_rsp_mst.vld=0
  - sram_cs=0
  - sram_addr and pkt.ir are don't-care but must not be X on vld.
- First request accepted: cycle after rst_n rises.

## Test plan
- **Single fetch:** pc=0x0000_0010 with SRAM word 4 = 32'h0010_0093, rsp.rdy=1.
  - Cycle N: sram_cs=1, sram_addr=4.
  - Cycle N+1: vld=1, ir=32'h0010_0093.
- **Streaming:** back-to-back pcs 0x0, 0x4, 0x8, 0xC with rsp.rdy=1.
  - Four responses on consecutive cycles, in order, words 0..3.
  - req.rdy stays 1 throughout.
- **Back-pressure:** stream with rsp.rdy=0 for 4 cycles, RSP_DEPTH=2.
  - Two requests accepted, then req.rdy=0.
  - The first response is held stable while rdy=0.
  - After rdy=1, both responses arrive in order with no loss.
  - req.rdy rises in the same cycle as the first pop.
- **Out of range:** pc=0x0000_4000 with ADDR_WIDTH=12.
  - sram_cs=0.
  - Next cycle: vld=1, ir=32'h0000_0000.
  - A following in-range fetch is unaffected.
- **Reset mid-operation:** two responses buffered, then rst_n=0 for one edge.
  - Next cycle: vld=0, req.rdy=1 once rst_n=1, occ=0.
  - No stale response ever appears.
- **Random:** random vld/rdy for 10k cycles against a scoreboard.
  - In-order, one response per accepted request.
  - occ never exceeds RSP_DEPTH.
